// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and buffer-control bundle for the pipeline scheduler
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MDU  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic go;
        logic clear;
    } buf_ctrl_t;

    typedef struct packed {
        logic      pc_go;
        buf_ctrl_t if_id;
        buf_ctrl_t id_exe;
        buf_ctrl_t exe_mem;
        buf_ctrl_t mem_wb;
    } pipe_ctrl_t;

    // Bit order: pc_go, {go,clear} for IF_ID, ID_EXE, EXE_MEM, MEM_WB
    localparam pipe_ctrl_t CTRL_RUN    = 9'b1_10_10_10_10;
    localparam pipe_ctrl_t CTRL_HOLD   = 9'b0_00_00_00_00;
    localparam pipe_ctrl_t CTRL_FLUSH  = 9'b1_11_11_10_10;
    localparam pipe_ctrl_t CTRL_MDU    = 9'b0_00_00_11_10;
    localparam pipe_ctrl_t CTRL_BUBBLE = 9'b0_00_11_10_10;

endpackage

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - load-use hazard comparator between the ID instruction and a load in EXE
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       exe_is_load,
    input  logic [4:0] exe_rd,
    output logic       hazard
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs && (id_rs == exe_rd);
    assign rt_hit = id_uses_rt && (id_rt == exe_rd);
    // Writes to $zero never produce a value, so they cannot create a dependency
    assign hazard = exe_is_load && (exe_rd != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush scheduler driving the inter-stage buffers and PC enable
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             exe_is_load,
    input  logic [4:0]       exe_rd,
    input  logic             exe_branch_taken,
    input  logic             exe_mdu_start,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_go,
    output logic             if_id_go,
    output logic             if_id_clear,
    output logic             id_exe_go,
    output logic             id_exe_clear,
    output logic             exe_mem_go,
    output logic             exe_mem_clear,
    output logic             mem_wb_go,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MCNT_W = $clog2(MDU_LAT);
    localparam logic [MCNT_W-1:0] MDU_LOAD = MCNT_W'(MDU_LAT - 2);

    state_e            state_q, state_d;
    state_e            ret_q, ret_d;
    logic [MCNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic              halt_req_q;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              load_use;
    logic              halt_edge;
    logic              flush_evt;
    logic              stall_evt;
    pipe_ctrl_t        ctrl;

    hazard_cmp u_hazard_cmp (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .exe_is_load (exe_is_load),
        .exe_rd      (exe_rd),
        .hazard      (load_use)
    );

    assign halt_edge = halt_req && !halt_req_q;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        mdu_cnt_d = mdu_cnt_q;
        ctrl      = CTRL_RUN;
        flush_evt = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt_edge) begin
                    ctrl    = CTRL_HOLD;
                    ret_d   = ST_RUN;
                    state_d = ST_HALT;
                end else if (exe_branch_taken) begin
                    ctrl      = CTRL_FLUSH;
                    flush_evt = 1'b1;
                end else if (exe_mdu_start) begin
                    ctrl      = CTRL_MDU;
                    mdu_cnt_d = MDU_LOAD;
                    state_d   = ST_MDU;
                end else if (load_use) begin
                    ctrl = CTRL_BUBBLE;
                end
            end
            ST_MDU: begin
                if (halt_edge) begin
                    ctrl    = CTRL_HOLD;
                    ret_d   = ST_MDU;
                    state_d = ST_HALT;
                end else if (mdu_cnt_q != '0) begin
                    ctrl      = CTRL_MDU;
                    mdu_cnt_d = mdu_cnt_q - MCNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                // mdu_cnt stays frozen so an interrupted op finishes its residency
                ctrl = CTRL_HOLD;
                if (resume) begin
                    state_d = ret_q;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (!rst_n) begin
            ctrl      = CTRL_HOLD;
            flush_evt = 1'b0;
        end
    end

    assign stall_evt = (state_q != ST_HALT) && !ctrl.pc_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            ret_q       <= ST_RUN;
            mdu_cnt_q   <= '0;
            halt_req_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            mdu_cnt_q  <= mdu_cnt_d;
            halt_req_q <= halt_req;
            if (stall_evt && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign pc_go         = ctrl.pc_go;
    assign if_id_go      = ctrl.if_id.go;
    assign if_id_clear   = ctrl.if_id.clear;
    assign id_exe_go     = ctrl.id_exe.go;
    assign id_exe_clear  = ctrl.id_exe.clear;
    assign exe_mem_go    = ctrl.exe_mem.go;
    assign exe_mem_clear = ctrl.exe_mem.clear;
    assign mem_wb_go     = ctrl.mem_wb.go;
    assign halted        = (state_q == ST_HALT);
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule
